// File: rtl/alu.sv
// Registered 8/16-bit ALU for the CPU datapath.
// Results and flags (bit0 Z, bit1 C, bit2 V, bit3 N) appear one clock after sampling.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] oper,
  input  logic [7:0] a_in_lo,
  input  logic [7:0] a_in_hi,
  input  logic [7:0] b_in,
  input  logic [3:0] proc_flags_in,
  output logic [7:0] out_lo,
  output logic [7:0] out_hi,
  output logic [3:0] proc_flags_out
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADC   = 5'd1,  OP_SUB   = 5'd2,  OP_SBC  = 5'd3,
    OP_CMP   = 5'd4,  OP_AND   = 5'd5,  OP_ORR   = 5'd6,  OP_XOR  = 5'd7,
    OP_INV   = 5'd8,  OP_INVP  = 5'd9,  OP_NEG   = 5'd10, OP_NEGP = 5'd11,
    OP_LSL   = 5'd12, OP_LSR   = 5'd13, OP_ASR   = 5'd14, OP_ROL  = 5'd15,
    OP_ROR   = 5'd16, OP_ROLC  = 5'd17, OP_RORC  = 5'd18, OP_LSLP = 5'd19,
    OP_LSRP  = 5'd20, OP_ASRP  = 5'd21, OP_ROLP  = 5'd22, OP_RORP = 5'd23,
    OP_ROLCP = 5'd24, OP_RORCP = 5'd25
  } op_e;

  logic [15:0] pair;
  logic        cin;
  logic        vin;

  assign pair = {a_in_hi, a_in_lo};
  assign cin  = proc_flags_in[1];
  assign vin  = proc_flags_in[2];

  // Subtraction is a + ~b + carry, so C=1 means no borrow.
  logic [7:0] b_op;
  logic       carry_add;
  logic [8:0] sum9;
  logic       sum_v;

  always_comb begin
    b_op      = b_in;
    carry_add = 1'b0;
    case (oper)
      OP_ADC:         carry_add = cin;
      OP_SUB, OP_CMP: begin b_op = ~b_in; carry_add = 1'b1; end
      OP_SBC:         begin b_op = ~b_in; carry_add = cin;  end
      default:        ;
    endcase
  end

  assign sum9  = {1'b0, a_in_lo} + {1'b0, b_op} + {8'd0, carry_add};
  assign sum_v = (a_in_lo[7] == b_op[7]) && (sum9[7] != a_in_lo[7]);

  logic [8:0]  neg9;
  logic [16:0] neg17;

  assign neg9  = {1'b0, ~a_in_lo} + 9'd1;
  assign neg17 = {1'b0, ~pair} + 17'd1;

  // Shifts keep one extra bit to catch the last bit shifted out; amounts past the
  // width are clamped so the extended vector saturates to zero or sign fill.
  logic [3:0]  amt8;
  logic [4:0]  amt16;
  logic [8:0]  lsl9, lsr9, asr9;
  logic [16:0] lsl17, lsr17, asr17;

  assign amt8  = (b_in > 8'd9)  ? 4'd9  : b_in[3:0];
  assign amt16 = (b_in > 8'd17) ? 5'd17 : b_in[4:0];

  assign lsl9  = {1'b0, a_in_lo} << amt8;
  assign lsr9  = {a_in_lo, 1'b0} >> amt8;
  assign asr9  = $signed({a_in_lo, 1'b0}) >>> amt8;
  assign lsl17 = {1'b0, pair} << amt16;
  assign lsr17 = {pair, 1'b0} >> amt16;
  assign asr17 = $signed({pair, 1'b0}) >>> amt16;

  logic [2:0]  k8;
  logic [3:0]  k16;
  logic [7:0]  rol8, ror8;
  logic [15:0] rol16, ror16;
  logic [8:0]  rc9, rolc9, rorc9;
  logic [16:0] rc17, rolc17, rorc17;

  assign k8  = b_in[2:0];
  assign k16 = b_in[3:0];
  assign rc9  = {cin, a_in_lo};
  assign rc17 = {cin, pair};

  assign rol8   = (a_in_lo << k8)  | (a_in_lo >> (4'd8  - {1'b0, k8}));
  assign ror8   = (a_in_lo >> k8)  | (a_in_lo << (4'd8  - {1'b0, k8}));
  assign rol16  = (pair << k16)    | (pair >> (5'd16 - {1'b0, k16}));
  assign ror16  = (pair >> k16)    | (pair << (5'd16 - {1'b0, k16}));
  assign rolc9  = (rc9 << k8)      | (rc9 >> (4'd9  - {1'b0, k8}));
  assign rorc9  = (rc9 >> k8)      | (rc9 << (4'd9  - {1'b0, k8}));
  assign rolc17 = (rc17 << k16)    | (rc17 >> (5'd17 - {1'b0, k16}));
  assign rorc17 = (rc17 >> k16)    | (rc17 << (5'd17 - {1'b0, k16}));

  logic [15:0] res;
  logic [15:0] nz_src;
  logic        wide;
  logic        known;
  logic        c_n;
  logic        v_n;
  logic        flag_n;
  logic        flag_z;

  always_comb begin
    res   = 16'h0000;
    wide  = 1'b0;
    known = 1'b1;
    c_n   = cin;
    v_n   = vin;
    case (oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res = {8'h00, sum9[7:0]};
        c_n = sum9[8];
        v_n = sum_v;
      end
      OP_CMP: begin
        res = {8'h00, a_in_lo};
        c_n = sum9[8];
        v_n = sum_v;
      end
      OP_AND:  res = {8'h00, a_in_lo & b_in};
      OP_ORR:  res = {8'h00, a_in_lo | b_in};
      OP_XOR:  res = {8'h00, a_in_lo ^ b_in};
      OP_INV:  res = {8'h00, ~a_in_lo};
      OP_INVP: begin res = ~pair; wide = 1'b1; end
      OP_NEG: begin
        res = {8'h00, neg9[7:0]};
        c_n = neg9[8];
        v_n = (a_in_lo == 8'h80);
      end
      OP_NEGP: begin
        res  = neg17[15:0];
        wide = 1'b1;
        c_n  = neg17[16];
        v_n  = (pair == 16'h8000);
      end
      OP_LSL: begin res = {8'h00, lsl9[7:0]}; c_n = (b_in == 8'd0) ? cin : lsl9[8]; end
      OP_LSR: begin res = {8'h00, lsr9[8:1]}; c_n = (b_in == 8'd0) ? cin : lsr9[0]; end
      OP_ASR: begin res = {8'h00, asr9[8:1]}; c_n = (b_in == 8'd0) ? cin : asr9[0]; end
      OP_ROL:  res = {8'h00, rol8};
      OP_ROR:  res = {8'h00, ror8};
      OP_ROLC: begin res = {8'h00, rolc9[7:0]}; c_n = rolc9[8]; end
      OP_RORC: begin res = {8'h00, rorc9[7:0]}; c_n = rorc9[8]; end
      OP_LSLP: begin
        res = lsl17[15:0]; wide = 1'b1;
        c_n = (b_in == 8'd0) ? cin : lsl17[16];
      end
      OP_LSRP: begin
        res = lsr17[16:1]; wide = 1'b1;
        c_n = (b_in == 8'd0) ? cin : lsr17[0];
      end
      OP_ASRP: begin
        res = asr17[16:1]; wide = 1'b1;
        c_n = (b_in == 8'd0) ? cin : asr17[0];
      end
      OP_ROLP:  begin res = rol16; wide = 1'b1; end
      OP_RORP:  begin res = ror16; wide = 1'b1; end
      OP_ROLCP: begin res = rolc17[15:0]; wide = 1'b1; c_n = rolc17[16]; end
      OP_RORCP: begin res = rorc17[15:0]; wide = 1'b1; c_n = rorc17[16]; end
      default:  known = 1'b0;
    endcase
  end

  // cmp reports the flags of the subtraction while passing A through.
  always_comb begin
    nz_src = (oper == OP_CMP) ? {8'h00, sum9[7:0]} : res;
    flag_n = wide ? nz_src[15] : nz_src[7];
    flag_z = wide ? (nz_src == 16'h0000) : (nz_src[7:0] == 8'h00);
  end

  logic [7:0] out_lo_q, out_lo_d;
  logic [7:0] out_hi_q, out_hi_d;
  logic [3:0] flags_q, flags_d;

  assign out_lo_d = res[7:0];
  assign out_hi_d = res[15:8];
  assign flags_d  = known ? {flag_n, v_n, c_n, flag_z} : proc_flags_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      flags_q  <= 4'h0;
    end else begin
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign out_lo         = out_lo_q;
  assign out_hi         = out_hi_q;
  assign proc_flags_out = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed and swept stimulus for alu; expectations queued at drive time and
// checked when the registered result appears.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] oper;
  logic [7:0] a_in_lo;
  logic [7:0] a_in_hi;
  logic [7:0] b_in;
  logic [3:0] proc_flags_in;
  logic [7:0] out_lo;
  logic [7:0] out_hi;
  logic [3:0] proc_flags_out;

  always #5 clk = ~clk;

  alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .oper          (oper),
    .a_in_lo       (a_in_lo),
    .a_in_hi       (a_in_hi),
    .b_in          (b_in),
    .proc_flags_in (proc_flags_in),
    .out_lo        (out_lo),
    .out_hi        (out_hi),
    .proc_flags_out(proc_flags_out)
  );

  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed hi/lo/flags=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    logic [19:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("[TB] %s -> hi=%h lo=%h flags=%b", t, out_hi, out_lo, proc_flags_out);
      check(t, {out_hi, out_lo, proc_flags_out}, e);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [7:0] alo,
                      input logic [7:0] ahi, input logic [7:0] b, input logic [3:0] f,
                      input logic [19:0] exp);
    @(negedge clk);
    drain();
    oper          = op;
    a_in_lo       = alo;
    a_in_hi       = ahi;
    b_in          = b;
    proc_flags_in = f;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Reference model: exact signed arithmetic and bit-at-a-time shifting.
  function automatic logic [19:0] model(input logic [4:0] op, input logic [7:0] alo,
                                        input logic [7:0] ahi, input logic [7:0] b,
                                        input logic [3:0] fin);
    int unsigned w, mask, p, r, s, k;
    int          sa, sb, sr, ci;
    bit          c, v, nc, n, z, do_cmp;
    logic [7:0]  lo, hi;
    c      = fin[1];
    v      = fin[2];
    do_cmp = 1'b0;
    w      = (op inside {5'd9, 5'd11, [5'd19:5'd25]}) ? 16 : 8;
    mask   = (w == 16) ? 32'hFFFF : 32'hFF;
    p      = {16'h0, ahi, alo};
    r      = 0;
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
        ci = (op == 5'd0) ? 0 : ((op == 5'd2 || op == 5'd4) ? 1 : int'(fin[1]));
        sa = int'(alo) - (alo[7] ? 256 : 0);
        sb = int'(b) - (b[7] ? 256 : 0);
        if (op < 5'd2) begin
          s  = int'(alo) + int'(b) + ci;
          sr = sa + sb + ci;
        end else begin
          s  = int'(alo) + (255 - int'(b)) + ci;
          sr = sa - sb - (1 - ci);
        end
        r      = s & 255;
        c      = (s > 255);
        v      = (sr > 127) || (sr < -128);
        do_cmp = (op == 5'd4);
      end
      5'd5: r = int'(alo & b);
      5'd6: r = int'(alo | b);
      5'd7: r = int'(alo ^ b);
      5'd8: r = 255 - int'(alo);
      5'd9: r = 65535 - p;
      5'd10: begin r = (256 - int'(alo)) & 255; c = (alo == 0); v = (alo == 8'h80); end
      5'd11: begin r = (65536 - p) & 65535; c = (p == 0); v = (p == 32768); end
      5'd12, 5'd13, 5'd14, 5'd19, 5'd20, 5'd21: begin
        r = (w == 16) ? p : int'(alo);
        for (int i = 0; i < int'(b); i++) begin
          if (op == 5'd12 || op == 5'd19) begin
            c = ((r >> (w - 1)) & 1) != 0;
            r = (r << 1) & mask;
          end else if (op == 5'd13 || op == 5'd20) begin
            c = (r & 1) != 0;
            r = r >> 1;
          end else begin
            c = (r & 1) != 0;
            r = (r >> 1) | (r & (1 << (w - 1)));
          end
        end
      end
      5'd15, 5'd16, 5'd22, 5'd23: begin
        r = (w == 16) ? p : int'(alo);
        k = int'(b) % w;
        for (int i = 0; i < int'(k); i++) begin
          if (op == 5'd15 || op == 5'd22) r = ((r << 1) | (r >> (w - 1))) & mask;
          else                            r = (r >> 1) | ((r & 1) << (w - 1));
        end
      end
      5'd17, 5'd18, 5'd24, 5'd25: begin
        r = (w == 16) ? p : int'(alo);
        k = int'(b) % w;
        for (int i = 0; i < int'(k); i++) begin
          if (op == 5'd17 || op == 5'd24) begin
            nc = ((r >> (w - 1)) & 1) != 0;
            r  = ((r << 1) | int'(c)) & mask;
          end else begin
            nc = (r & 1) != 0;
            r  = (r >> 1) | (int'(c) << (w - 1));
          end
          c = nc;
        end
      end
      default: return {16'h0000, fin};
    endcase
    n  = ((r >> (w - 1)) & 1) != 0;
    z  = (r == 0);
    lo = do_cmp ? alo : r[7:0];
    hi = (w == 16) ? r[15:8] : 8'h00;
    return {hi, lo, n, v, c, z};
  endfunction

  logic [7:0] a_list[6];
  logic [7:0] b_list[10];

  initial begin
    rst_n = 1'b0; oper = 5'd0; a_in_lo = 8'h00; a_in_hi = 8'h00;
    b_in = 8'h00; proc_flags_in = 4'h0;
    a_list = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h00};
    b_list = '{8'h00, 8'h01, 8'h07, 8'h08, 8'h09, 8'h0F, 8'h10, 8'h11, 8'hFF, 8'h00};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Put a nonzero result in flight, then reset asynchronously mid-cycle.
    step("inflight add 7F+01", 5'd0, 8'h7F, 8'h00, 8'h01, 4'h0, {8'h00, 8'h80, 4'b1100});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset immediate", {out_hi, out_lo, proc_flags_out}, 20'h0);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1 check("reset held across edge", {out_hi, out_lo, proc_flags_out}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("add 03+04",          5'd0,  8'h03, 8'h00, 8'h04, 4'b0000, {8'h00, 8'h07, 4'b0000});
    step("add 7F+01",          5'd0,  8'h7F, 8'h00, 8'h01, 4'b0000, {8'h00, 8'h80, 4'b1100});
    step("sub 00-01",          5'd2,  8'h00, 8'h00, 8'h01, 4'b0000, {8'h00, 8'hFF, 4'b1000});
    step("cmp 00,01",          5'd4,  8'h00, 8'h00, 8'h01, 4'b0000, {8'h00, 8'h00, 4'b1000});
    step("lslp 8001<<1",       5'd19, 8'h01, 8'h80, 8'h01, 4'b0000, {8'h00, 8'h02, 4'b0010});
    step("rorc 01 C=1 by 1",   5'd18, 8'h01, 8'h00, 8'h01, 4'b0010, {8'h00, 8'h80, 4'b1010});
    step("asr 80 by 9",        5'd14, 8'h80, 8'h00, 8'h09, 4'b0000, {8'h00, 8'hFF, 4'b1010});
    step("lsl by 0 keeps C",   5'd12, 8'h81, 8'h00, 8'h00, 4'b0010, {8'h00, 8'h81, 4'b1010});
    step("lsr 80 by 8",        5'd13, 8'h80, 8'h00, 8'h08, 4'b0000, {8'h00, 8'h00, 4'b0011});
    step("negp 8000",          5'd11, 8'h00, 8'h80, 8'h00, 4'b0000, {8'h80, 8'h00, 4'b1100});
    step("undefined 26",       5'd26, 8'h12, 8'h34, 8'h56, 4'b1011, {8'h00, 8'h00, 4'b1011});
    step("and keeps C/V",      5'd5,  8'hF0, 8'h00, 8'h0F, 4'b0110, {8'h00, 8'h00, 4'b0111});

    for (int op = 0; op < 32; op++) begin
      for (int ai = 0; ai < 6; ai++) begin
        for (int bi = 0; bi < 10; bi++) begin
          for (int c = 0; c < 2; c++) begin
            logic [7:0] alo, ahi, b;
            logic [3:0] f;
            alo = (ai == 5) ? 8'($urandom_range(0, 255)) : a_list[ai];
            b   = (bi == 9) ? 8'($urandom_range(0, 255)) : b_list[bi];
            ahi = 8'($urandom_range(0, 255));
            f   = 4'($urandom_range(0, 15));
            f[1] = c[0];
            step($sformatf("op%0d a=%h%h b=%h f=%b", op, ahi, alo, b, f),
                 5'(op), alo, ahi, b, f, model(5'(op), alo, ahi, b, f));
          end
        end
      end
    end

    @(negedge clk);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
